// File: rtl/host_mem_responder_if.sv
// Host DMA handshake bundle shared by mem_ctrl (master) and the host responder (slave).
interface host_mem_responder_if #(
    parameter int CL_SIZE_WIDTH = 512,
    parameter int ADDR_BITCOUNT = 64
) ();

    logic [ADDR_BITCOUNT-1:0] addr;
    logic                     host_rgo;
    logic                     host_wgo;
    logic                     host_we;
    logic [CL_SIZE_WIDTH-1:0] host_data_bus_write_out;
    logic [CL_SIZE_WIDTH-1:0] host_data_bus_read_in;
    logic                     host_init;
    logic                     host_rd_ready;
    logic                     host_wr_ready;

    modport master (
        output addr, host_rgo, host_wgo, host_we, host_data_bus_write_out,
        input  host_data_bus_read_in, host_init, host_rd_ready, host_wr_ready
    );

    modport slave (
        input  addr, host_rgo, host_wgo, host_we, host_data_bus_write_out,
        output host_data_bus_read_in, host_init, host_rd_ready, host_wr_ready
    );

endinterface

// File: rtl/host_mem_responder.sv
// Host-side responder: answers rgo/wgo go requests after a fixed latency and
// sources/sinks whole cache lines from a small line store that is zeroed
// after every reset.
module host_mem_responder #(
    parameter int CL_SIZE_WIDTH = 512,
    parameter int ADDR_BITCOUNT = 64,
    parameter int DEPTH         = 16,
    parameter int RD_LATENCY    = 4,
    parameter int WR_LATENCY    = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    host_mem_responder_if.slave  bus,
    output logic                 addr_err,
    output logic                 protocol_err,
    output logic [31:0]          rd_count,
    output logic [31:0]          wr_count
);

    localparam int IDX_W   = $clog2(DEPTH);
    localparam int MAX_LAT = (RD_LATENCY > WR_LATENCY) ? RD_LATENCY : WR_LATENCY;
    localparam int CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

    typedef enum logic [2:0] {
        INIT,
        IDLE,
        RD_WAIT,
        RD_READY,
        WR_WAIT,
        WR_READY
    } state_t;

    state_t                   state;
    state_t                   next_state;

    logic [CL_SIZE_WIDTH-1:0] mem [DEPTH];
    logic [CL_SIZE_WIDTH-1:0] read_data;
    logic [IDX_W-1:0]         clr_idx;
    logic [IDX_W-1:0]         rd_idx;
    logic [CNT_W-1:0]         lat_cnt;

    logic                     cnt_load;
    logic [CNT_W-1:0]         cnt_load_val;
    logic                     cnt_dec;
    logic                     rd_accept;
    logic                     rd_fetch;
    logic                     rd_done;
    logic                     wr_strobe;
    logic                     clr_step;

    logic [IDX_W-1:0]         addr_idx;
    logic                     addr_high_nz;
    logic                     mem_we;
    logic [IDX_W-1:0]         mem_widx;
    logic [CL_SIZE_WIDTH-1:0] mem_wdata;

    // Bits above the index wrap silently, but are flagged through addr_err.
    assign addr_idx     = bus.addr[IDX_W-1:0];
    assign addr_high_nz = |bus.addr[ADDR_BITCOUNT-1:IDX_W];

    // The clearing walk and host write strobes share the single store write port.
    assign mem_we    = clr_step | wr_strobe;
    assign mem_widx  = clr_step ? clr_idx : addr_idx;
    assign mem_wdata = clr_step ? '0 : bus.host_data_bus_write_out;

    // Ready and init flags come straight from state so reset drops them at once.
    assign bus.host_init             = (state != INIT);
    assign bus.host_rd_ready         = (state == RD_READY);
    assign bus.host_wr_ready         = (state == WR_READY);
    assign bus.host_data_bus_read_in = read_data;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= INIT;
        else     state <= next_state;
    end

    // Next-state decode, datapath strobes and the error pulses of the sampling cycle.
    always_comb begin
        next_state   = state;
        cnt_load     = 1'b0;
        cnt_load_val = '0;
        cnt_dec      = 1'b0;
        rd_accept    = 1'b0;
        rd_fetch     = 1'b0;
        rd_done      = 1'b0;
        wr_strobe    = 1'b0;
        clr_step     = 1'b0;
        addr_err     = 1'b0;
        protocol_err = 1'b0;
        case (state)
            INIT: begin
                clr_step = 1'b1;
                if (clr_idx == IDX_W'(DEPTH - 1)) next_state = IDLE;
            end
            IDLE: begin
                if (bus.host_rgo) begin
                    rd_accept    = 1'b1;
                    cnt_load     = 1'b1;
                    cnt_load_val = CNT_W'(RD_LATENCY - 1);
                    addr_err     = addr_high_nz;
                    protocol_err = bus.host_wgo | bus.host_we;
                    next_state   = RD_WAIT;
                end else if (bus.host_wgo) begin
                    cnt_load     = 1'b1;
                    cnt_load_val = CNT_W'(WR_LATENCY - 1);
                    protocol_err = bus.host_we;
                    next_state   = WR_WAIT;
                end else if (bus.host_we) begin
                    protocol_err = 1'b1;
                end
            end
            RD_WAIT: begin
                if (!bus.host_rgo) begin
                    next_state = IDLE;
                end else if (lat_cnt == '0) begin
                    rd_fetch   = 1'b1;
                    next_state = RD_READY;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            RD_READY: begin
                if (!bus.host_rgo) begin
                    rd_done    = 1'b1;
                    next_state = IDLE;
                end
            end
            WR_WAIT: begin
                if (!bus.host_wgo) begin
                    next_state = IDLE;
                end else if (lat_cnt == '0) begin
                    next_state = WR_READY;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            WR_READY: begin
                if (bus.host_we) begin
                    wr_strobe = 1'b1;
                    addr_err  = addr_high_nz;
                end
                if (!bus.host_wgo) next_state = IDLE;
            end
            default: next_state = INIT;
        endcase
    end

    // Clear index walks the store once per INIT pass and restarts on every reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)           clr_idx <= '0;
        else if (clr_step) clr_idx <= clr_idx + 1'b1;
    end

    // Latency counter shared by the read and write wait states.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)           lat_cnt <= '0;
        else if (cnt_load) lat_cnt <= cnt_load_val;
        else if (cnt_dec)  lat_cnt <= lat_cnt - 1'b1;
    end

    // Read index is captured at accept so addr may move during the wait.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)            rd_idx <= '0;
        else if (rd_accept) rd_idx <= addr_idx;
    end

    // Read line register holds its value until the next completed fetch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)           read_data <= '0;
        else if (rd_fetch) read_data <= mem[rd_idx];
    end

    // Line store write port; its contents are rebuilt by INIT after reset.
    always_ff @(posedge clk) begin
        if (mem_we) mem[mem_widx] <= mem_wdata;
    end

    // Completed reads and accepted write strobes, wrapping modulo 2^32.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_count <= '0;
            wr_count <= '0;
        end else begin
            if (rd_done)   rd_count <= rd_count + 32'd1;
            if (wr_strobe) wr_count <= wr_count + 32'd1;
        end
    end

endmodule

// File: tb/tb_host_mem_responder.sv
// Bench for host_mem_responder: directed scenarios plus random reads/writes,
// scored against an array model of the line store and a queue of expected reads.
module tb_host_mem_responder;

    localparam int CLW   = 512;
    localparam int AW    = 64;
    localparam int DEPTH = 16;
    localparam int RDL   = 4;
    localparam int WRL   = 2;

    typedef struct {
        logic [CLW-1:0] data;
        int             accept_cyc;
    } rd_exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        addr_err;
    logic        protocol_err;
    logic [31:0] rd_count;
    logic [31:0] wr_count;

    host_mem_responder_if #(.CL_SIZE_WIDTH(CLW), .ADDR_BITCOUNT(AW)) bus ();

    host_mem_responder #(
        .CL_SIZE_WIDTH(CLW),
        .ADDR_BITCOUNT(AW),
        .DEPTH(DEPTH),
        .RD_LATENCY(RDL),
        .WR_LATENCY(WRL)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus),
        .addr_err(addr_err),
        .protocol_err(protocol_err),
        .rd_count(rd_count),
        .wr_count(wr_count)
    );

    always #5 clk = ~clk;

    int             checks = 0;
    int             failures = 0;
    int             cyc = 0;
    rd_exp_t        exp_q[$];
    rd_exp_t        mon_e;
    logic           prev_rd_ready = 1'b0;
    logic [CLW-1:0] model_mem [DEPTH];
    int unsigned    model_rd = 0;
    int unsigned    model_wr = 0;
    int             exp_ae = 0, seen_ae = 0;
    int             exp_pe = 0, seen_pe = 0;
    logic [AW-1:0]  wbuf_addr [4];
    logic [CLW-1:0] wbuf_data [4];

    // Free-running cycle counter used for latency measurements.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_output(input string name, input logic [CLW-1:0] act,
                                input logic [CLW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Monitor: pops the expected line whenever rd_ready rises and tallies error pulses.
    always @(negedge clk) begin
        if (rst) begin
            prev_rd_ready <= 1'b0;
        end else begin
            if (addr_err)     seen_ae++;
            if (protocol_err) seen_pe++;
            if (bus.host_rd_ready && !prev_rd_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("[TB] FAIL unexpected_rd_ready actual=1 expected=0");
                end else begin
                    mon_e = exp_q.pop_front();
                    check_output("rd_data", bus.host_data_bus_read_in, mon_e.data);
                    check_output("rd_latency", CLW'(cyc - mon_e.accept_cyc), CLW'(RDL));
                end
            end
            prev_rd_ready <= bus.host_rd_ready;
        end
    end

    function automatic logic [CLW-1:0] rand_line();
        logic [CLW-1:0] v;
        for (int i = 0; i < CLW / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    function automatic logic [AW-1:0] rand_addr();
        logic [AW-1:0] a;
        a = {$urandom, $urandom};
        if ($urandom_range(0, 3) != 0) a[AW-1:4] = '0;
        return a;
    endfunction

    task automatic apply_stimulus_idle();
        bus.addr                    = '0;
        bus.host_rgo                = 1'b0;
        bus.host_wgo                = 1'b0;
        bus.host_we                 = 1'b0;
        bus.host_data_bus_write_out = '0;
    endtask

    task automatic clear_model();
        for (int i = 0; i < DEPTH; i++) model_mem[i] = '0;
        model_rd = 0;
        model_wr = 0;
        exp_q.delete();
    endtask

    // Expect host_init low for DEPTH-1 edges after reset release and high on edge DEPTH.
    task automatic check_init_sequence();
        logic early;
        early = 1'b0;
        for (int k = 1; k <= DEPTH; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (k < DEPTH && bus.host_init) early = 1'b1;
        end
        check_output("init_early", CLW'(early), CLW'(1'b0));
        check_output("init_high", CLW'(bus.host_init), CLW'(1'b1));
    endtask

    task automatic do_read(input logic [AW-1:0] a, input int hold, input bit with_wgo);
        rd_exp_t ent;
        bit      got;
        bit      hi;
        @(posedge clk); #1;
        bus.addr     = a;
        bus.host_rgo = 1'b1;
        bus.host_wgo = with_wgo;
        hi = |a[AW-1:4];
        ent.data       = model_mem[a[3:0]];
        ent.accept_cyc = cyc + 1;
        exp_q.push_back(ent);
        if (hi) exp_ae++;
        if (with_wgo) exp_pe++;
        @(negedge clk);
        check_output("rd_addr_err", CLW'(addr_err), CLW'(hi));
        if (with_wgo) check_output("rd_wgo_protocol_err", CLW'(protocol_err), CLW'(1'b1));
        @(posedge clk); #1;
        bus.host_wgo = 1'b0;
        bus.addr     = rand_addr();
        got = 1'b0;
        for (int k = 0; k < RDL + 10 && !got; k++) begin
            @(negedge clk);
            if (bus.host_rd_ready) got = 1'b1;
        end
        check_output("rd_ready_timeout", CLW'(got), CLW'(1'b1));
        repeat (hold) @(negedge clk);
        @(posedge clk); #1;
        bus.host_rgo = 1'b0;
        @(posedge clk);
        if (got) model_rd++;
        @(negedge clk);
        check_output("rd_ready_drop", CLW'(bus.host_rd_ready), CLW'(1'b0));
        check_output("rd_count", CLW'(rd_count), CLW'(model_rd));
    endtask

    task automatic do_write(input int n);
        int acc;
        bit got;
        bit hi;
        @(posedge clk); #1;
        bus.host_wgo = 1'b1;
        bus.addr     = rand_addr();
        acc = cyc + 1;
        got = 1'b0;
        for (int k = 0; k < WRL + 10 && !got; k++) begin
            @(negedge clk);
            if (bus.host_wr_ready) got = 1'b1;
        end
        check_output("wr_ready_timeout", CLW'(got), CLW'(1'b1));
        check_output("wr_latency", CLW'(cyc - acc), CLW'(WRL));
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            bus.host_we                 = 1'b1;
            bus.addr                    = wbuf_addr[i];
            bus.host_data_bus_write_out = wbuf_data[i];
            hi = |wbuf_addr[i][AW-1:4];
            if (hi) exp_ae++;
            @(negedge clk);
            check_output("wr_ready_held", CLW'(bus.host_wr_ready), CLW'(1'b1));
            check_output("wr_addr_err", CLW'(addr_err), CLW'(hi));
            model_mem[wbuf_addr[i][3:0]] = wbuf_data[i];
            model_wr++;
        end
        @(posedge clk); #1;
        bus.host_we  = 1'b0;
        bus.host_wgo = 1'b0;
        @(posedge clk);
        @(negedge clk);
        check_output("wr_ready_drop", CLW'(bus.host_wr_ready), CLW'(1'b0));
        check_output("wr_count", CLW'(wr_count), CLW'(model_wr));
    endtask

    // Watchdog: a hung handshake still ends the run with a visible failure.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [CLW-1:0] a5;
        logic [CLW-1:0] pre;
        bit             seen_rdy;
        int             n;
        a5 = {64{8'hA5}};
        rst = 1'b1;
        apply_stimulus_idle();
        clear_model();
        repeat (3) @(posedge clk);
        #1;
        check_output("rst_init", CLW'(bus.host_init), CLW'(1'b0));
        check_output("rst_rd_ready", CLW'(bus.host_rd_ready), CLW'(1'b0));
        check_output("rst_wr_ready", CLW'(bus.host_wr_ready), CLW'(1'b0));
        check_output("rst_counts", CLW'({rd_count, wr_count}), CLW'(64'd0));
        check_output("rst_read_in", bus.host_data_bus_read_in, '0);
        rst = 1'b0;
        check_init_sequence();

        $display("[TB] cleared store read");
        do_read(64'd5, 0, 1'b0);

        $display("[TB] write then read index 3");
        wbuf_addr[0] = 64'd3;
        wbuf_data[0] = a5;
        do_write(1);
        do_read(64'd3, 1, 1'b0);

        $display("[TB] high address bits wrap");
        wbuf_addr[0] = 64'h1_0000_0007;
        wbuf_data[0] = CLW'(16'h1234);
        do_write(1);
        do_read(64'd7, 0, 1'b0);

        $display("[TB] protocol errors");
        do_read(64'd3, 0, 1'b1);
        @(posedge clk); #1;
        bus.host_we                 = 1'b1;
        bus.addr                    = 64'd3;
        bus.host_data_bus_write_out = rand_line();
        exp_pe++;
        @(negedge clk);
        check_output("idle_we_protocol_err", CLW'(protocol_err), CLW'(1'b1));
        @(posedge clk); #1;
        bus.host_we = 1'b0;
        do_read(64'd3, 0, 1'b0);

        $display("[TB] double strobe window");
        wbuf_addr[0] = 64'd2;
        wbuf_data[0] = CLW'(8'h11);
        wbuf_addr[1] = 64'd2;
        wbuf_data[1] = CLW'(8'h22);
        pre = CLW'(model_wr);
        do_write(2);
        check_output("double_strobe_count", CLW'(wr_count) - pre, CLW'(2));
        do_read(64'd2, 0, 1'b0);

        $display("[TB] random traffic");
        for (int it = 0; it < 40; it++) begin
            if ($urandom_range(0, 1) == 0) begin
                do_read(rand_addr(), int'($urandom_range(0, 2)), 1'b0);
            end else begin
                n = int'($urandom_range(0, 3));
                for (int i = 0; i < 4; i++) begin
                    wbuf_addr[i] = rand_addr();
                    wbuf_data[i] = rand_line();
                end
                do_write(n);
            end
        end

        $display("[TB] aborted read");
        @(posedge clk); #1;
        bus.host_rgo = 1'b1;
        bus.addr     = 64'd4;
        repeat (3) @(posedge clk);
        #1;
        bus.host_rgo = 1'b0;
        seen_rdy = 1'b0;
        for (int k = 0; k < RDL + 4; k++) begin
            @(negedge clk);
            if (bus.host_rd_ready) seen_rdy = 1'b1;
        end
        check_output("abort_no_ready", CLW'(seen_rdy), CLW'(1'b0));
        check_output("abort_rd_count", CLW'(rd_count), CLW'(model_rd));

        $display("[TB] reset during write window");
        @(posedge clk); #1;
        bus.host_wgo = 1'b1;
        seen_rdy = 1'b0;
        for (int k = 0; k < WRL + 10 && !seen_rdy; k++) begin
            @(negedge clk);
            if (bus.host_wr_ready) seen_rdy = 1'b1;
        end
        check_output("pre_reset_wr_ready", CLW'(seen_rdy), CLW'(1'b1));
        #2;
        rst = 1'b1;
        #1;
        check_output("midrst_wr_ready", CLW'(bus.host_wr_ready), CLW'(1'b0));
        check_output("midrst_init", CLW'(bus.host_init), CLW'(1'b0));
        check_output("midrst_counts", CLW'({rd_count, wr_count}), CLW'(64'd0));
        check_output("midrst_read_in", bus.host_data_bus_read_in, '0);
        apply_stimulus_idle();
        clear_model();
        @(posedge clk); #1;
        rst = 1'b0;
        check_init_sequence();
        do_read(64'd3, 0, 1'b0);

        repeat (2) @(negedge clk);
        check_output("queue_drained", CLW'(exp_q.size()), CLW'(0));
        check_output("addr_err_pulses", CLW'(seen_ae), CLW'(exp_ae));
        check_output("protocol_err_pulses", CLW'(seen_pe), CLW'(exp_pe));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/host_mem_responder.md
Name: host_mem_responder

Overview:
- Host-side responder for the host DMA handshake driven by mem_ctrl.
- Accepts read and write go requests (host_rgo / host_wgo) and asserts host_rd_ready / host_wr_ready after a programmable latency.
- Sources or sinks full cache lines from a small internal line store.
- Used as the host endpoint in emulation and in block-level benches, so mem_ctrl and the cache controller can run without the real DMA shell.

Parameters:
- CL_SIZE_WIDTH, 512, cache line width in bits.
- ADDR_BITCOUNT, 64, width of the line address.
- DEPTH, 16, number of lines in the store; power of two, >= 2.
- RD_LATENCY, 4, cycles from read accept to host_rd_ready; >= 1.
- WR_LATENCY, 2, cycles from write accept to host_wr_ready; >= 1.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- addr  in  ADDR_BITCOUNT  line address; index = addr[$clog2(DEPTH)-1:0].
- host_rgo  in  1  read request, held until host_rd_ready is seen.
- host_wgo  in  1  write request, held until the write completes.
- host_we  in  1  write strobe; line is committed in this cycle.
- host_data_bus_write_out  in  CL_SIZE_WIDTH  write line from the controller.
- host_data_bus_read_in  out  CL_SIZE_WIDTH  read line to the controller.
- host_init  out  1  store initialised; held high until reset.
- host_rd_ready  out  1  read data valid.
- host_wr_ready  out  1  ready to take host_we.
- addr_err  out  1  one-cycle pulse: high address bits were nonzero at sampling.
- protocol_err  out  1  one-cycle pulse: illegal request combination.
- rd_count  out  32  completed reads, wraps modulo 2^32.
- wr_count  out  32  accepted host_we strobes, wraps modulo 2^32.

Behaviour:
- One clock is used throughout.
- Reset is asynchronous and active-high.
- During rst, all outputs are 0, state = INIT, and the clear index and latency counter are 0.

INIT:
- Writes zero to one entry per cycle, index 0..DEPTH-1.
- host_init rises on the cycle after the last entry is cleared: DEPTH cycles after reset deasserts.
- All request inputs are ignored while in INIT.

IDLE:
- host_rgo=1: sample the index from addr, go to RD_WAIT, load the counter with RD_LATENCY-1.
- host_wgo=1 with host_rgo=0: go to WR_WAIT, load the counter with WR_LATENCY-1.
- host_rgo and host_wgo both high: the read wins and protocol_err pulses.
- host_we in IDLE: ignored and protocol_err pulses.
- host_re-style pops from the controller do not reach this block.

RD_WAIT:
- Counter decrements each cycle.
- At 0: register host_data_bus_read_in <= mem[index] and go to RD_READY.
- host_rgo dropping before then: abort to IDLE; no rd_ready, rd_count unchanged.

RD_READY:
- host_rd_ready=1; data is held stable.
- Stays here while host_rgo=1.
- When host_rgo=0: go to IDLE, drop host_rd_ready, rd_count +1.
- host_data_bus_read_in retains its last value until the next read.

WR_WAIT:
- Counter decrements each cycle; at 0 go to WR_READY.
- host_wgo dropping early: abort to IDLE.

WR_READY:
- host_wr_ready=1, held while host_wgo=1.
- On each cycle with host_we=1: sample the index from addr in that same cycle, write mem[index] <= host_data_bus_write_out, wr_count +1.
- Several strobes in one window each write; the last write to an index wins.
- host_wgo=0: go to IDLE.
- The controller inserts a one-cycle bubble between seeing wr_ready and asserting host_we. The responder holds host_wr_ready across that bubble.

Address rules:
- Read addresses are sampled at accept; write addresses are sampled at host_we.
- Nonzero addr above the index bits: addr_err pulses in the sampling cycle, and the access proceeds on the low index bits (wrap-around).

Reset mid-operation:
- Immediate return to INIT.
- host_init, host_rd_ready and host_wr_ready drop asynchronously.
- Counts clear and the store is re-cleared.

Test Plan:
1. Reset release -> host_init=0 for 16 cycles, then 1. A read of index 5 returns 512'h0.
2. wgo with addr=3, we on the second wr_ready cycle with data 512'hA5A5…A5 -> wr_ready rises 2 cycles after accept. wr_count=1. A read of addr 3 gives rd_ready 4 cycles after accept with data A5A5…A5, then rd_count=1 after rgo drops.
3. addr=64'h1_0000_0007 write with data 512'h1234, then read addr 7 -> addr_err pulses once on the write. The read returns 512'h1234.
4. rgo and wgo both asserted in IDLE -> protocol_err pulses once and the read path is taken. host_we in IDLE -> protocol_err pulses and memory is unchanged.
5. rgo dropped 2 cycles into RD_WAIT -> no rd_ready and rd_count unchanged. Then assert rst during WR_READY -> all outputs 0 immediately, and host_init returns 16 cycles after release.
6. Two host_we strobes in one WR_READY window to index 2, data 512'h11 then 512'h22 -> wr_count=2. A read of index 2 returns 512'h22.
